// File: rtl/noc_pkg.sv
// noc_pkg: shared flit types, head-flit field layout and sequence-number width for the mesh NoC
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'b00,
        FLIT_BODY     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    localparam int NOC_X_W   = 2;
    localparam int NOC_Y_W   = 2;
    localparam int NOC_LEN_W = 3;

    localparam int DST_X_OFF = 0;
    localparam int DST_Y_OFF = DST_X_OFF + NOC_X_W;
    localparam int SRC_X_OFF = DST_Y_OFF + NOC_Y_W;
    localparam int SRC_Y_OFF = SRC_X_OFF + NOC_X_W;
    localparam int LEN_OFF   = SRC_Y_OFF + NOC_Y_W;
    localparam int HDR_W     = LEN_OFF + NOC_LEN_W;

    localparam int SEQ_W = 8;

    typedef struct packed {
        logic [SEQ_W-1:0]     seq;
        logic [NOC_LEN_W-1:0] len;
        logic [NOC_Y_W-1:0]   src_y;
        logic [NOC_X_W-1:0]   src_x;
        logic [NOC_Y_W-1:0]   dst_y;
        logic [NOC_X_W-1:0]   dst_x;
    } noc_head_t;

endpackage

// File: rtl/noc_flit_reg.sv
// noc_flit_reg: single flit holding register that stays stable while the consumer stalls
module noc_flit_reg
    import noc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  flit_type_e   in_type,
    input  logic [W-1:0] in_data,
    output logic         load_en,
    output logic         out_valid,
    input  logic         out_ready,
    output flit_type_e   out_type,
    output logic [W-1:0] out_data
);

    assign load_en = !out_valid || out_ready;

    // capture a new flit whenever the register is empty or being drained
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_type  <= FLIT_HEAD;
            out_data  <= '0;
        end else if (load_en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_type <= in_type;
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/noc_ni_tx.sv
// noc_ni_tx: transmit NI packetizing descriptor + payload into head/body/tail flits (option: NOC_NI_TX_SEQNUM_EN)
module noc_ni_tx
    import noc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int X_W     = 2,
    parameter int Y_W     = 2,
    parameter int SRC_X   = 0,
    parameter int SRC_Y   = 0,
    parameter int MAX_LEN = 4,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [X_W-1:0]    msg_dst_x,
    input  logic [Y_W-1:0]    msg_dst_y,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              pld_valid,
    output logic              pld_ready,
    input  logic [DATA_W-1:0] pld_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [1:0]        flit_type,
    output logic [DATA_W-1:0] flit_data,
    output logic              busy,
    output logic              err_len
);

    localparam int HEAD_W = 2*X_W + 2*Y_W + LEN_W;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]        state;
    logic [LEN_W-1:0]  rem;
    logic [LEN_W-1:0]  len_sat;
    logic              len_ovf;
    logic              load_en;
    logic              msg_fire;
    logic              pld_fire;
    logic              in_valid;
    flit_type_e        in_type;
    flit_type_e        out_type;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] in_data;

    assign msg_ready = !rst && state == ST_IDLE && load_en;
    assign pld_ready = !rst && state == ST_BODY && load_en;
    assign msg_fire  = msg_valid && msg_ready;
    assign pld_fire  = pld_valid && pld_ready;
    assign len_ovf   = msg_len > LEN_W'(MAX_LEN);
    assign len_sat   = len_ovf ? LEN_W'(MAX_LEN) : msg_len;

`ifdef NOC_NI_TX_SEQNUM_EN
    logic [SEQ_W-1:0] seq;

    // count every accepted descriptor, wrapping at 256
    always_ff @(posedge clk) begin
        if (rst) seq <= '0;
        else if (msg_fire) seq <= seq + SEQ_W'(1);
    end
`endif

    // head flit: routing fields packed from the LSB, unused upper bits zero
    always_comb begin
        head = '0;
        head[HEAD_W-1:0] = {len_sat, Y_W'(SRC_Y), X_W'(SRC_X), msg_dst_y, msg_dst_x};
`ifdef NOC_NI_TX_SEQNUM_EN
        head[HEAD_W+SEQ_W-1:HEAD_W] = seq;
`endif
    end

    assign in_valid = msg_fire || pld_fire;
    assign in_type  = msg_fire ? (len_sat == '0 ? FLIT_HEADTAIL : FLIT_HEAD)
                               : (rem == LEN_W'(1) ? FLIT_TAIL : FLIT_BODY);
    assign in_data  = msg_fire ? head : pld_data;

    // packet FSM: IDLE takes descriptors, BODY counts payload words down to the tail
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rem     <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= msg_fire && len_ovf;
            if (msg_fire && len_sat != '0) begin
                state <= ST_BODY;
                rem   <= len_sat;
            end else if (pld_fire) begin
                rem   <= rem - LEN_W'(1);
                state <= rem == LEN_W'(1) ? ST_IDLE : ST_BODY;
            end
        end
    end

    noc_flit_reg #(.W(DATA_W)) u_flit_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_type  (in_type),
        .in_data  (in_data),
        .load_en  (load_en),
        .out_valid(flit_valid),
        .out_ready(flit_ready),
        .out_type (out_type),
        .out_data (flit_data)
    );

    assign flit_type = out_type;
    assign busy      = state != ST_IDLE || flit_valid;

endmodule

// File: tb/tb_noc_ni_tx.sv
// tb_noc_ni_tx: directed scoreboard bench for noc_ni_tx (honours NOC_NI_TX_SEQNUM_EN)
module tb_noc_ni_tx;
    import noc_pkg::*;

    localparam int SX = 0;
    localparam int SY = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [1:0]  msg_dst_x = '0;
    logic [1:0]  msg_dst_y = '0;
    logic [2:0]  msg_len = '0;
    logic        pld_valid = 1'b0;
    logic        pld_ready;
    logic [31:0] pld_data = '0;
    logic        flit_valid;
    logic        flit_ready = 1'b1;
    logic [1:0]  flit_type;
    logic [31:0] flit_data;
    logic        busy;
    logic        err_len;

    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    logic [33:0] sb[$];
    int          hs_cyc[$];
    logic [33:0] exp_f;
    logic [7:0]  seq = '0;

    noc_ni_tx #(.DATA_W(32), .X_W(2), .Y_W(2), .SRC_X(SX), .SRC_Y(SY), .MAX_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_dst_x (msg_dst_x),
        .msg_dst_y (msg_dst_y),
        .msg_len   (msg_len),
        .pld_valid (pld_valid),
        .pld_ready (pld_ready),
        .pld_data  (pld_data),
        .flit_valid(flit_valid),
        .flit_ready(flit_ready),
        .flit_type (flit_type),
        .flit_data (flit_data),
        .busy      (busy),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_no++;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] hd(input int dx, input int dy, input int len);
        hd = 32'(dx) | (32'(dy) << 2) | (32'(SX) << 4) | (32'(SY) << 6) | (32'(len) << 8);
`ifdef NOC_NI_TX_SEQNUM_EN
        hd = hd | (32'(seq) << 11);
`endif
    endfunction

    // every flit handshake pops one expected flit from the scoreboard
    always @(negedge clk) begin
        if (!rst && flit_valid && flit_ready) begin
            hs_cyc.push_back(cyc_no);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_flit observed=%0h expected=none", {flit_type, flit_data});
            end else begin
                exp_f = sb.pop_front();
                chk("flit", {30'd0, flit_type, flit_data}, {30'd0, exp_f});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_msg(input int dx, input int dy, input int len, input int hlen);
        msg_valid = 1'b1;
        msg_dst_x = 2'(dx);
        msg_dst_y = 2'(dy);
        msg_len   = 3'(len);
        #1;
        for (int i = 0; i < 50 && !msg_ready; i++) begin
            @(posedge clk);
            #2;
        end
        if (!msg_ready) begin
            checks++;
            errors++;
            $error("FAIL msg_timeout observed=0 expected=1");
        end else begin
            sb.push_back({hlen == 0 ? 2'b11 : 2'b00, hd(dx, dy, hlen)});
            seq++;
            @(posedge clk);
            #1;
        end
        msg_valid = 1'b0;
    endtask

    task automatic send_pld(input logic [31:0] d, input bit last);
        pld_valid = 1'b1;
        pld_data  = d;
        #1;
        for (int i = 0; i < 50 && !pld_ready; i++) begin
            @(posedge clk);
            #2;
        end
        if (!pld_ready) begin
            checks++;
            errors++;
            $error("FAIL pld_timeout observed=0 expected=1");
        end else begin
            sb.push_back({last ? 2'b10 : 2'b01, d});
            @(posedge clk);
            #1;
        end
        pld_valid = 1'b0;
    endtask

    initial begin
        msg_valid = 1'b1;
        cyc(2);
        chk("rst_flit_valid", flit_valid, 0);
        chk("rst_flit_type", flit_type, 0);
        chk("rst_flit_data", flit_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_msg_ready", msg_ready, 0);
        chk("rst_pld_ready", pld_ready, 0);
        msg_valid = 1'b0;
        rst = 1'b0;
        cyc(1);
        chk("idle_msg_ready", msg_ready, 1);
        // single-flit packet
        send_msg(1, 2, 0, 0);
        chk("t1_busy", busy, 1);
        chk("t1_type", flit_type, 3);
        chk("t1_hdr", flit_data[9:0], 10'h009);
        cyc(1);
        chk("t1_busy_drop", busy, 0);
        chk("t1_valid_drop", flit_valid, 0);
        // len=3 streamed at full rate
        send_msg(0, 1, 3, 3);
        send_pld(32'hA1, 0);
        send_pld(32'hA2, 0);
        send_pld(32'hA3, 1);
        cyc(2);
        chk("t2_consecutive", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-4], 3);
        chk("t2_idle", busy, 0);
        // backpressure mid-packet
        send_msg(3, 3, 3, 3);
        send_pld(32'hB1, 0);
        flit_ready = 1'b0;
        pld_valid  = 1'b1;
        pld_data   = 32'hB2;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", flit_valid, 1);
            chk("t3_type", flit_type, 1);
            chk("t3_data", flit_data, 32'hB1);
            chk("t3_pld_ready", pld_ready, 0);
            @(posedge clk);
            #2;
        end
        flit_ready = 1'b1;
        pld_valid  = 1'b0;
        send_pld(32'hB2, 0);
        send_pld(32'hB3, 1);
        cyc(2);
        // back-to-back single-word packets
        send_msg(2, 0, 1, 1);
        send_pld(32'hC1, 1);
        send_msg(1, 1, 1, 1);
        send_pld(32'hC2, 1);
        cyc(2);
        chk("t4_no_bubble", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-4], 3);
        // oversize length saturates and flags
        send_msg(1, 0, 7, 4);
        chk("t5_err_pulse", err_len, 1);
        chk("t5_head_type", flit_type, 0);
        chk("t5_head_len", flit_data[10:8], 4);
        send_pld(32'hD1, 0);
        chk("t5_err_drop", err_len, 0);
        send_pld(32'hD2, 0);
        send_pld(32'hD3, 0);
        send_pld(32'hD4, 1);
        pld_valid = 1'b1;
        pld_data  = 32'hD5;
        #1;
        chk("t5_no_5th_word", pld_ready, 0);
        chk("t5_back_idle", msg_ready, 1);
        pld_valid = 1'b0;
        cyc(2);
        // reset mid-body drops the packet
        send_msg(2, 2, 2, 2);
        send_pld(32'hE1, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_msg_ready", msg_ready, 0);
        chk("t6_rst_pld_ready", pld_ready, 0);
        cyc(1);
        chk("t6_valid_cleared", flit_valid, 0);
        chk("t6_busy_cleared", busy, 0);
        rst = 1'b0;
        sb.delete();
        seq = '0;
        send_msg(3, 1, 0, 0);
        send_msg(1, 3, 1, 1);
        send_pld(32'hF1, 1);
        cyc(3);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
